// File: rtl/vga_pkg.sv
// Shared VGA timing constants, 24-bit colour type and colour-bar palette.
// Used by vga_timing_gen and vga_scan_out (bar palette only with VGA_TEST_PATTERN_EN).
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int H_FP_DEF         = 16;
  localparam int H_SYNC_DEF       = 96;
  localparam int H_BP_DEF         = 48;
  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;

  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_FP_DEF         = 10;
  localparam int V_SYNC_DEF       = 2;
  localparam int V_BP_DEF         = 33;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic rgb_t barColour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus horizontal/vertical scan counters and the raw
// (unregistered) sync, active and end-of-frame flags derived from them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_pe,
  output logic [COORD_W-1:0] o_hcount,
  output logic [COORD_W-1:0] o_vcount,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active,
  output logic               o_frameEnd
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SS   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SE   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SS   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SE   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic               r_pe;
  logic [COORD_W-1:0] r_hcount;
  logic [COORD_W-1:0] r_vcount;
  logic               w_hLast;
  logic               w_vLast;

  assign w_hLast = (r_hcount == H_LAST);
  assign w_vLast = (r_vcount == V_LAST);

  // Wrap on equality with the last value, so counters never exceed total-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pe     <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_pe <= ~r_pe;
      if (r_pe) begin
        if (w_hLast) begin
          r_hcount <= '0;
          r_vcount <= w_vLast ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign o_pe       = r_pe;
  assign o_hcount   = r_hcount;
  assign o_vcount   = r_vcount;
  assign o_hsync    = ~((r_hcount >= H_SS) && (r_hcount <= H_SE));
  assign o_vsync    = ~((r_vcount >= V_SS) && (r_vcount <= V_SE));
  assign o_active   = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign o_frameEnd = w_hLast && w_vLast;

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: frame-latched colour, one-slot-delayed registered video outputs.
// Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:0]        pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic               vga_clk,
  output logic               frame_start,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y
);

  logic               w_pe;
  logic [COORD_W-1:0] w_hcount;
  logic [COORD_W-1:0] w_vcount;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_active;
  logic               w_frameEnd;
  logic               w_load;
  rgb_t               w_pixColour;

  rgb_t               r_colour;
  rgb_t               r_rgb;
  logic               r_hs;
  logic               r_vs;
  logic               r_blankN;
  logic               r_vgaClk;
  logic               r_frameStart;
  logic [COORD_W-1:0] r_posX;
  logic [COORD_W-1:0] r_posY;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk      (clk),
    .i_rst      (reset),
    .o_pe       (w_pe),
    .o_hcount   (w_hcount),
    .o_vcount   (w_vcount),
    .o_hsync    (w_hsync),
    .o_vsync    (w_vsync),
    .o_active   (w_active),
    .o_frameEnd (w_frameEnd)
  );

  // Colour only changes on the last slot of a frame so no frame ever tears.
  assign w_load = w_pe && w_frameEnd;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_ACTIVE / 8);

  logic       r_testMode;
  logic [2:0] w_barIdx;

  assign w_barIdx = 3'(w_hcount / BAR_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_colour   <= '0;
      r_testMode <= 1'b0;
    end else if (w_load) begin
      r_colour   <= pix_data;
      r_testMode <= test_mode;
    end
  end

  always_comb begin
    w_pixColour = r_colour;
    if (r_testMode) begin
      w_pixColour = barColour(w_barIdx);
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_colour <= '0;
    end else if (w_load) begin
      r_colour <= pix_data;
    end
  end

  assign w_pixColour = r_colour;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb    <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_blankN <= 1'b0;
      r_posX   <= '0;
      r_posY   <= '0;
    end else if (w_pe) begin
      r_rgb    <= w_active ? w_pixColour : '0;
      r_hs     <= w_hsync;
      r_vs     <= w_vsync;
      r_blankN <= w_active;
      r_posX   <= w_hcount;
      r_posY   <= w_vcount;
    end
  end

  // vga_clk rises one clk after the outputs change, i.e. mid-slot for the DAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vgaClk     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_vgaClk     <= ~w_pe;
      r_frameStart <= w_load;
    end
  end

  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blankN;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = r_vgaClk;
  assign frame_start = r_frameStart;
  assign pos_x       = r_posX;
  assign pos_y       = r_posY;

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out with a reduced raster so several frames fit.
// The reference model predicts each pixel slot from elapsed clocks since reset release.
module tb_vga_scan_out;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
  } vid_t;

  logic        clk;
  logic        reset;
  logic [23:0] pixData;
  logic        testMode;
  logic [7:0]  vgaR, vgaG, vgaB;
  logic        vgaHs, vgaVs, vgaBlankN, vgaSyncN, vgaClk, frameStart;
  logic [9:0]  posX, posY;

  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   n = 0;
  logic expVclk = 1'b0;
  logic expFs   = 1'b0;
  logic [23:0] modelColour = '0;
  logic        modelTest   = 1'b0;
  vid_t expQ[$];

  logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_data    (pixData),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (testMode),
`endif
    .vga_r       (vgaR),
    .vga_g       (vgaG),
    .vga_b       (vgaB),
    .vga_hs      (vgaHs),
    .vga_vs      (vgaVs),
    .vga_blank_n (vgaBlankN),
    .vga_sync_n  (vgaSyncN),
    .vga_clk     (vgaClk),
    .frame_start (frameStart),
    .pos_x       (posX),
    .pos_y       (posY)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, n);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] pix, input int cycles);
    pixData = pix;
`ifdef VGA_TEST_PATTERN_EN
    testMode = 1'($urandom_range(0, 1));
`endif
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference model: slot k (1-based) is latched on clk edge 2k and shows pixel k-1;
  // its expectation is queued on the following odd edge, when vga_clk rises.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n           = 0;
      expVclk     = 1'b0;
      expFs       = 1'b0;
      modelColour = '0;
      modelTest   = 1'b0;
      expQ.delete();
    end else begin
      vid_t e;
      int   p, x, y;
      logic act;
      logic [23:0] c;
      n++;
      expVclk = n[0];
      expFs   = (n % 2 == 0) && ((n / 2) % FRAME == 0);
      if (n == 1) begin
        e = '{x: 10'd0, y: 10'd0, rgb: 24'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0};
        expQ.push_back(e);
      end else if (n % 2 == 1) begin
        p   = (n - 3) / 2;
        x   = p % HT;
        y   = (p / HT) % VT;
        act = (x < HA) && (y < VA);
        c   = modelTest ? barTable[x / (HA / 8)] : modelColour;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.rgb   = act ? c : 24'd0;
        e.hs    = !(x >= HA + HFP && x < HA + HFP + HSW);
        e.vs    = !(y >= VA + VFP && y < VA + VFP + VSW);
        e.blank = act;
        expQ.push_back(e);
      end
      if (expFs) begin
        modelColour = pixData;
`ifdef VGA_TEST_PATTERN_EN
        modelTest = testMode;
`endif
      end
    end
  end

  // Monitor: reset values while in reset, otherwise clock phase every clk and
  // one video comparison per DAC sample (vga_clk high).
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset values",
                  64'({posX, posY, vgaR, vgaG, vgaB, vgaHs, vgaVs, vgaBlankN, vgaClk, frameStart}),
                  64'({10'd0, 10'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    end else begin
      checkOutput("vga_clk/frame_start/sync_n",
                  64'({vgaClk, frameStart, vgaSyncN}), 64'({expVclk, expFs, 1'b0}));
      if (vgaClk) begin
        checkOutput("scoreboard not empty", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
          vid_t e, a;
          e = expQ.pop_front();
          a = '{x: posX, y: posY, rgb: {vgaR, vgaG, vgaB}, hs: vgaHs, vs: vgaVs, blank: vgaBlankN};
          checkOutput("pixel {x,y,rgb,hs,vs,blank}", 64'(a), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit reached;
    reset    = 1'b1;
    pixData  = 24'h00FF00;
    testMode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // First frame black, second frame green.
    applyStimulus(24'h00FF00, 4 * FRAME + 60);

    // Random mid-frame colour changes must wait for the next frame boundary.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(24'($urandom()), int'($urandom_range(150, 500)));
    end

    // Abort a frame at counter position (10,4) with a 3-clk reset pulse.
    reached = 0;
    for (int i = 0; i < 4 * FRAME && !reached; i++) begin
      @(posedge clk);
      #1;
      reached = (n >= 2 * FRAME) && (n % 2 == 0) && ((n / 2) % FRAME == 4 * HT + 10);
    end
    checkOutput("mid-frame reset point reached", 64'(reached), 64'd1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(24'($urandom()), 2 * FRAME + 100);
    applyStimulus(24'($urandom()), 2 * FRAME + 77);

    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
